full_handshake_rx: RTL and testbench

//  Receive end of the four-phase CDC handshake: consumes req/data from the TX-side sender in another clock domain.

---
 rtl/full_handshake_rx.sv | 77 +++++++
 tb/tb_full_handshake_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/full_handshake_rx.sv
// Receive side of a four-phase CDC handshake: synchronises req, captures one word per
// request, hands it to the consumer with valid/ready and acknowledges only after the word is taken.
module full_handshake_rx #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic          recv_valid_o,
  output logic [DW-1:0] recv_data_o,
  input  logic          recv_ready_i
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HOLD = 3'b010,
    ACK  = 3'b100
  } state_t;

  state_t state_r;
  logic   req_meta_r;
  logic   req_sync_r;

  // Two-flop req synchroniser plus the handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta_r   <= 1'b0;
      req_sync_r   <= 1'b0;
      state_r      <= IDLE;
      ack_o        <= 1'b0;
      recv_valid_o <= 1'b0;
      recv_data_o  <= {DW{1'b0}};
    end else begin
      req_meta_r <= req_i;
      req_sync_r <= req_meta_r;
      case (state_r)
        IDLE: begin
          // Data is sampled only here, so sender changes after capture never leak through.
          if (req_sync_r) begin
            recv_data_o  <= req_data_i;
            recv_valid_o <= 1'b1;
            state_r      <= HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          if (recv_valid_o && recv_ready_i) begin
            recv_valid_o <= 1'b0;
            ack_o        <= 1'b1;
            state_r      <= ACK;
          end else begin
            state_r <= HOLD;
          end
        end
        ACK: begin
          // Leaving ACK needs req low, which guarantees a held req is delivered once.
          if (!req_sync_r) begin
            ack_o   <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= ACK;
          end
        end
        default: begin
          state_r      <= IDLE;
          ack_o        <= 1'b0;
          recv_valid_o <= 1'b0;
          recv_data_o  <= {DW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_full_handshake_rx.sv
// Directed bench for full_handshake_rx: latency, backpressure, single delivery,
// data-ignore, reset, and a streamed transfer from a sender model in a 7:3 slower clock domain.
`timescale 1ns/1ps
module tb_full_handshake_rx;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          tx_clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          ack_o;
  logic          recv_valid_o;
  logic [DW-1:0] recv_data_o;
  logic          recv_ready_i;

  int errors = 0;
  int checks = 0;

  always #3 clk = ~clk;
  always #7 tx_clk = ~tx_clk;

  full_handshake_rx #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_data_i   (req_data_i),
    .ack_o        (ack_o),
    .recv_valid_o (recv_valid_o),
    .recv_data_o  (recv_data_o),
    .recv_ready_i (recv_ready_i)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b1; req_data_i = 32'hDEADBEEF; recv_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1);
      checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack cyc%0d got=%b exp=0", c, ack_o); end
      checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got=%b exp=0", c, recv_valid_o); end
      checks++; if (recv_data_o !== 32'h0) begin errors++; $display("FAIL reset_data cyc%0d got=%h exp=0", c, recv_data_o); end
    end
    rst = 1'b0; req_i = 1'b0; req_data_i = 32'h0;
    step(4);
    checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", recv_valid_o); end
  endtask

  task automatic test_basic();
    req_i = 1'b1; req_data_i = 32'hDEADBEEF; recv_ready_i = 1'b1;
    step(2);
    checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_e2 got=%b exp=0", recv_valid_o); end
    step(1);
    checks++; if (recv_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_e3 got=%b exp=1", recv_valid_o); end
    checks++; if (recv_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data_e3 got=%h exp=deadbeef", recv_data_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL basic_ack_e3 got=%b exp=0", ack_o); end
    step(1);
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL basic_ack_e4 got=%b exp=1", ack_o); end
    checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_e4 got=%b exp=0", recv_valid_o); end
    req_i = 1'b0; req_data_i = 32'h0;
    step(2);
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL basic_ack_fall_e2 got=%b exp=1", ack_o); end
    step(1);
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL basic_ack_fall_e3 got=%b exp=0", ack_o); end
    step(3);
    checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got=%b exp=0", recv_valid_o); end
  endtask

  // Backpressure followed by a req held long after ack (single delivery).
  task automatic test_backpressure_single();
    int bad;
    int xfers;
    req_i = 1'b1; req_data_i = 32'hCAFE0001; recv_ready_i = 1'b0;
    step(3);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (recv_valid_o !== 1'b1 || recv_data_o !== 32'hCAFE0001 || ack_o !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0 (v=%b d=%h a=%b)", bad, recv_valid_o, recv_data_o, ack_o); end
    recv_ready_i = 1'b1;
    step(1);
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL backpressure_ack got=%b exp=1", ack_o); end
    checks++; if (recv_valid_o !== 1'b0) begin errors++; $display("FAIL backpressure_valid_drop got=%b exp=0", recv_valid_o); end
    xfers = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (recv_valid_o === 1'b1 && recv_ready_i === 1'b1) xfers++;
    end
    checks++; if (xfers !== 0) begin errors++; $display("FAIL single_delivery extra_transfers=%0d exp=0", xfers); end
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL single_ack_held got=%b exp=1", ack_o); end
    req_i = 1'b0; req_data_i = 32'h0;
    step(3);
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL single_ack_release got=%b exp=0", ack_o); end
    step(2);
  endtask

  task automatic test_data_ignore();
    req_i = 1'b1; req_data_i = 32'hDEADBEEF; recv_ready_i = 1'b0;
    step(3);
    req_data_i = 32'h0;
    step(2);
    checks++; if (recv_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ignore_hold_data got=%h exp=deadbeef", recv_data_o); end
    recv_ready_i = 1'b1;
    step(1);
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL ignore_ack got=%b exp=1", ack_o); end
    checks++; if (recv_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ignore_ack_data got=%h exp=deadbeef", recv_data_o); end
    req_i = 1'b0;
    step(5);
    checks++; if (recv_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ignore_idle_data got=%h exp=deadbeef", recv_data_o); end
  endtask

  // Sender model on tx_clk against a random-ready consumer on clk; checks order, loss and duplicates.
  task automatic run_stream(input int n, input string tag);
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    int timeouts;
    int bad;
    timeouts = 0;
    for (int i = 0; i < n; i++) sent.push_back($urandom);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int t;
          @(posedge tx_clk); #1;
          req_data_i = sent[i]; req_i = 1'b1;
          t = 0;
          while (ack_o !== 1'b1 && t < 200) begin @(posedge tx_clk); #1; t++; end
          if (t >= 200) timeouts++;
          req_i = 1'b0; req_data_i = 32'h0;
          t = 0;
          while (ack_o !== 1'b0 && t < 200) begin @(posedge tx_clk); #1; t++; end
          if (t >= 200) timeouts++;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 40000) begin
          @(negedge clk);
          recv_ready_i = 1'($urandom_range(0, 1));
          if (recv_valid_o === 1'b1 && recv_ready_i === 1'b1) got.push_back(recv_data_o);
          cyc++;
        end
      end
    join
    recv_ready_i = 1'b1;
    step(10);
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL %s_timeouts got=%0d exp=0", tag, timeouts); end
    checks++; if (got.size() !== n) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, got.size(), n); end
    bad = 0;
    for (int i = 0; i < n && i < got.size(); i++) if (got[i] !== sent[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s_order mismatched_words=%0d exp=0", tag, bad); end
  endtask

  task automatic test_back_to_back();
    int t;
    run_stream(100, "stream");
    // Reset while in ACK with req still high, then the sender restarts cleanly.
    req_i = 1'b1; req_data_i = 32'h12345678; recv_ready_i = 1'b1;
    t = 0;
    while (ack_o !== 1'b1 && t < 20) begin step(1); t++; end
    checks++; if (ack_o !== 1'b1) begin errors++; $display("FAIL midrst_reach_ack got=%b exp=1", ack_o); end
    rst = 1'b1; req_i = 1'b0; req_data_i = 32'h0;
    step(1);
    checks++; if (ack_o !== 1'b0 || recv_valid_o !== 1'b0 || recv_data_o !== 32'h0) begin
      errors++; $display("FAIL midrst_clear got a=%b v=%b d=%h exp 0/0/0", ack_o, recv_valid_o, recv_data_o);
    end
    step(1);
    rst = 1'b0;
    step(3);
    run_stream(20, "rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure_single();
    test_data_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
